nios2_cpu_debug_ocimem: RTL and testbench
=========================================

# nios2_cpu_debug_ocimem

On-chip debug memory controller for the Nios II debug core, directly downstream of the debug-slave wrapper. Consumes the `jdo` payload and the `take_action_ocimem_*` strobes, executes JTAG-initiated reads/writes into a single-port debug RAM, and returns read data on `MonDReg`, which feeds back into the debug slave's scan register. It also arbitrates CPU-side Avalon-MM access to the same RAM, which holds the debug monitor code and data.

## Interface
- `ADDR_W`, 8, word-address width; RAM depth is 2^ADDR_W x 32 bits.
- `clk`  in  1  system clock (same domain as `jdo` and `take_action_*`).
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `jdo`  in  38  JTAG data-out payload; valid in any cycle where a strobe is high.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address; optionally request a read.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: sequential read at the current address.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write `jdo` data at the current address.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU request; held until `avs_waitrequest`=0.
- `avs_writedata`  in  32; `avs_byteenable`  in  4.
- `debugaccess`  in  1  CPU write permission; writes with `debugaccess`=0 are dropped.
- `avs_readdata`  out  32  CPU read data; valid when `avs_waitrequest`=0 on a read.
- `avs_waitrequest`  out  1  CPU stall.
- `MonDReg`  out  32  monitor data register returned to the debug slave.
- `jtag_busy`  out  1  high while any JTAG operation is pending or executing.

## Operation
- Registers: `MonAReg[ADDR_W-1:0]`, `MonDReg[31:0]`, `jrd_pend`, `jwr_pend`, and FSM `state`.
- `take_action_ocimem_a`: `MonAReg <= jdo[10+ADDR_W-1:10]`; if `jdo[35]`=1, set `jrd_pend`.
- `take_no_action_ocimem_a`: set `jrd_pend`; address unchanged.
- `take_action_ocimem_b`: `MonDReg <= jdo[34:3]`; set `jwr_pend`.
- Strobes are mutually exclusive. If more than one is asserted, `ocimem_b` takes precedence over `ocimem_a`, and `ocimem_a` takes precedence over `no_action`.
- FSM states: IDLE, JRD, JRD_CAP, JWR, CRD, CRD_DONE, CWR.
- IDLE priority, highest first: `jwr_pend` -> JWR; `jrd_pend` -> JRD; `avs_write` -> CWR; `avs_read` -> CRD.
- JRD: present `MonAReg` to the RAM, clear `jrd_pend`, go to JRD_CAP.
- JRD_CAP: `MonDReg <= ram_q`; `MonAReg <= MonAReg+1`; go to IDLE.
- JWR: write `MonDReg` to RAM[`MonAReg`] with all bytes enabled; clear `jwr_pend`; `MonAReg <= MonAReg+1`; go to IDLE.
- CRD: present `avs_address`; go to CRD_DONE. CRD_DONE: `avs_readdata <= ram_q` (combinational pass-through allowed); go to IDLE.
- CWR: if `debugaccess`, write `avs_writedata` to RAM[`avs_address`] using `avs_byteenable`; go to IDLE.
- Address increments wrap from 2^ADDR_W-1 to 0.
- CPU operations are non-preemptive: a JTAG strobe arriving mid-CPU-operation only sets its pend flag and is serviced from the next IDLE.
- A strobe arriving while the same pend flag is already set overwrites the address/data and the flag stays set; one operation results.
- `jtag_busy` = `jrd_pend | jwr_pend | state∈{JRD,JRD_CAP,JWR}`.

## Timing
- Reset values:
  - `MonDReg`=0, `MonAReg`=0, pend flags=0, state=IDLE.
  - `avs_readdata`=0, `avs_waitrequest`=1, `jtag_busy`=0.
- Reset mid-operation aborts the operation: no RAM write and no `MonDReg` update occur in the reset cycle. RAM contents are not cleared.
- JTAG read latency from an idle FSM:
  - Strobe at cycle N; pend visible at N+1; JRD at N+1; JRD_CAP at N+2.
  - New `MonDReg` is visible at N+3.
- JTAG write from an idle FSM:
  - `MonDReg` holds the `jdo` data at N+1.
  - The RAM write occurs in JWR at N+1.
  - `MonAReg` is incremented at N+2.
- `avs_waitrequest` is 0 only in CRD_DONE and CWR; it is 1 in all other states, including IDLE.
- CPU read: request seen in IDLE at T; completes at T+2, i.e. two wait cycles.
- CPU write: request seen in IDLE at T; completes at T+1, i.e. one wait cycle.
- RAM has a 1-cycle registered read.

## Test plan
- Reset, then JTAG write: `ocimem_a` with `jdo[17:10]`=0x10 and `jdo[35]`=0; then `ocimem_b` with `jdo[34:3]`=0xDEADBEEF.
  - Required: RAM[0x10]=0xDEADBEEF and `MonAReg`=0x11.
- JTAG readback: `ocimem_a` with addr 0x10 and `jdo[35]`=1.
  - Required: `MonDReg`=0xDEADBEEF exactly 3 cycles after the strobe.
  - Follow with `no_action` -> `MonDReg` = RAM[0x11].
- Wrap: write at address 0xFF, then `no_action`.
  - Required: read returns RAM[0x00] and `MonAReg`=0x01.
- CPU access:
  - Write 0x12345678 to address 3 with byteenable 4'b0011 and `debugaccess`=1; a prior value of 0xAAAAAAAA reads back as 0xAAAA5678 after two wait cycles.
  - The same write with `debugaccess`=0 leaves the word unchanged.
- Collision:
  - `avs_read` and `ocimem_a` (read) in the same cycle -> the JTAG read executes first and the CPU completes 3 cycles later with correct data.
  - A strobe during CRD -> serviced after CRD_DONE.
- Reset asserted in the JWR cycle -> RAM word unchanged, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/nios2_cpu_debug_ocimem_if.sv
// CPU-side Avalon-MM slave bus into the Nios II on-chip debug memory.
// The master drives requests and the slave returns read data and the stall.
interface nios2_cpu_debug_ocimem_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              debugaccess;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, debugaccess,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, debugaccess,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/nios2_cpu_debug_ocimem.sv
// Nios II on-chip debug memory controller: executes JTAG reads/writes from
// the debug slave into a single-port debug RAM and arbitrates CPU Avalon
// access to the same RAM. JTAG work always wins in IDLE, but a CPU access
// already in flight is never preempted.
module nios2_cpu_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [37:0]             jdo,
    input  logic                    take_action_ocimem_a,
    input  logic                    take_no_action_ocimem_a,
    input  logic                    take_action_ocimem_b,
    nios2_cpu_debug_ocimem_if.slave avs,
    output logic [31:0]             MonDReg,
    output logic                    jtag_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_JRD      = 3'd1,
        ST_JRD_CAP  = 3'd2,
        ST_JWR      = 3'd3,
        ST_CRD      = 3'd4,
        ST_CRD_DONE = 3'd5,
        ST_CWR      = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              jrd_pend_q, jrd_pend_d;
    logic              jwr_pend_q, jwr_pend_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              waitreq_q, waitreq_d;
    logic              busy_q, busy_d;

    logic [31:0]       ram_mem [DEPTH];
    logic [31:0]       ram_rdata_q;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [31:0]       ram_wdata_s;
    logic [3:0]        ram_be_s;
    logic              ram_we_s;

    logic              act_a_s, act_n_s, act_b_s;
    logic              jrd_req_s, jwr_req_s;
    logic [ADDR_W-1:0] areg_fsm_s;
    logic [31:0]       dreg_fsm_s;
    logic              jrd_fsm_s, jwr_fsm_s;
    logic              unused_jdo_s;

    // jdo bits outside the address/data/read-flag fields carry nothing here.
    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    // Resolve colliding strobes (b over a over no_action) and form requests
    // that include a strobe arriving this cycle, so IDLE reacts without delay.
    always_comb begin
        act_b_s   = take_action_ocimem_b;
        act_a_s   = take_action_ocimem_a & ~take_action_ocimem_b;
        act_n_s   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
        jwr_req_s = jwr_pend_q | act_b_s;
        jrd_req_s = jrd_pend_q | (act_a_s & jdo[35]) | act_n_s;
    end

    // Next-state, RAM port control and register updates; a strobe overrides
    // the FSM's own address increment / data capture in the same cycle.
    always_comb begin
        state_d     = state_q;
        areg_fsm_s  = mon_areg_q;
        dreg_fsm_s  = mon_dreg_q;
        jrd_fsm_s   = jrd_pend_q;
        jwr_fsm_s   = jwr_pend_q;
        readdata_d  = readdata_q;
        ram_addr_s  = mon_areg_q;
        ram_wdata_s = mon_dreg_q;
        ram_be_s    = 4'b1111;
        ram_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Pre-read the CPU address so CRD already holds the word.
                ram_addr_s = avs.avs_address;
                if (jwr_req_s) begin
                    state_d = ST_JWR;
                end else if (jrd_req_s) begin
                    state_d = ST_JRD;
                end else if (avs.avs_write) begin
                    state_d = ST_CWR;
                end else if (avs.avs_read) begin
                    state_d = ST_CRD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_JRD: begin
                ram_addr_s = mon_areg_q;
                jrd_fsm_s  = 1'b0;
                state_d    = ST_JRD_CAP;
            end
            ST_JRD_CAP: begin
                dreg_fsm_s = ram_rdata_q;
                areg_fsm_s = mon_areg_q + ADDR_W'(1);
                state_d    = ST_IDLE;
            end
            ST_JWR: begin
                ram_addr_s = mon_areg_q;
                ram_we_s   = 1'b1;
                jwr_fsm_s  = 1'b0;
                areg_fsm_s = mon_areg_q + ADDR_W'(1);
                state_d    = ST_IDLE;
            end
            ST_CRD: begin
                ram_addr_s = avs.avs_address;
                readdata_d = ram_rdata_q;
                state_d    = ST_CRD_DONE;
            end
            ST_CRD_DONE: begin
                state_d = ST_IDLE;
            end
            ST_CWR: begin
                ram_addr_s  = avs.avs_address;
                ram_wdata_s = avs.avs_writedata;
                ram_be_s    = avs.avs_byteenable;
                ram_we_s    = avs.debugaccess;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mon_areg_d = act_a_s ? jdo[10 +: ADDR_W] : areg_fsm_s;
        mon_dreg_d = act_b_s ? jdo[34:3] : dreg_fsm_s;
        jrd_pend_d = jrd_fsm_s | (act_a_s & jdo[35]) | act_n_s;
        jwr_pend_d = jwr_fsm_s | act_b_s;
        waitreq_d  = !((state_d == ST_CRD_DONE) || (state_d == ST_CWR));
        busy_d     = jrd_pend_d | jwr_pend_d | (state_d == ST_JRD) |
                     (state_d == ST_JRD_CAP) | (state_d == ST_JWR);
    end

    // Control and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mon_areg_q <= '0;
            mon_dreg_q <= 32'h0000_0000;
            jrd_pend_q <= 1'b0;
            jwr_pend_q <= 1'b0;
            readdata_q <= 32'h0000_0000;
            waitreq_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mon_areg_q <= mon_areg_d;
            mon_dreg_q <= mon_dreg_d;
            jrd_pend_q <= jrd_pend_d;
            jwr_pend_q <= jwr_pend_d;
            readdata_q <= readdata_d;
            waitreq_q  <= waitreq_d;
            busy_q     <= busy_d;
        end
    end

    // Debug RAM: byte-enabled write (suppressed in a reset cycle), registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be_s[b]) begin
                    ram_mem[ram_addr_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
                end
            end
        end
        ram_rdata_q <= ram_mem[ram_addr_s];
    end

    assign MonDReg             = mon_dreg_q;
    assign jtag_busy           = busy_q;
    assign avs.avs_readdata    = readdata_q;
    assign avs.avs_waitrequest = waitreq_q;
endmodule

// File: tb/tb_nios2_cpu_debug_ocimem.sv
// Bench for the debug memory controller: a directed vector table, hand-timed
// sequences for latency/collision/reset corners, then random transactions
// checked against an array model of the debug RAM and monitor registers.
module tb_nios2_cpu_debug_ocimem;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {OP_JA, OP_JN, OP_JB, OP_CW, OP_CR} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  addr;
        logic        rd;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_n, take_b;
    logic [31:0] mon_dreg;
    logic        jtag_busy;

    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[$];

    logic [31:0] mm [256];
    logic [7:0]  ma;
    logic [31:0] md;

    nios2_cpu_debug_ocimem_if #(.ADDR_W(ADDR_W)) avs_if ();

    nios2_cpu_debug_ocimem #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_n),
        .take_action_ocimem_b    (take_b),
        .avs                     (avs_if),
        .MonDReg                 (mon_dreg),
        .jtag_busy               (jtag_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic add(input op_e op, input logic [7:0] a, input logic rd, input logic [31:0] d,
                       input logic [3:0] be, input logic dbg, input logic chk, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.addr = a; v.rd = rd; v.data = d;
        v.be = be; v.dbg = dbg; v.chk = chk; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Fields not used by the strobe are filled with noise.
    task automatic set_strobe(input op_e op, input logic [7:0] a, input logic rd, input logic [31:0] d);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        jdo = r[37:0];
        case (op)
            OP_JA: begin jdo[17:10] = a; jdo[35] = rd; take_a = 1'b1; end
            OP_JN: take_n = 1'b1;
            OP_JB: begin jdo[34:3] = d; take_b = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic clear_strobes();
        take_a = 1'b0;
        take_n = 1'b0;
        take_b = 1'b0;
    endtask

    task automatic wait_jtag_idle();
        int k;
        k = 0;
        while (jtag_busy !== 1'b0 && k < 20) begin
            step();
            k++;
        end
        if (jtag_busy !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL jtag_timeout: busy=%b after %0d cycles, want 0", jtag_busy, k);
        end
    endtask

    task automatic jtag_op(input op_e op, input logic [7:0] a, input logic rd, input logic [31:0] d);
        set_strobe(op, a, rd, d);
        step();
        clear_strobes();
        wait_jtag_idle();
    endtask

    task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic dbg, output logic [31:0] rdata, output int lat);
        avs_if.avs_address    = a;
        avs_if.avs_writedata  = d;
        avs_if.avs_byteenable = be;
        avs_if.debugaccess    = dbg;
        avs_if.avs_write      = wr;
        avs_if.avs_read       = !wr;
        lat = 0;
        do begin
            step();
            lat++;
        end while (avs_if.avs_waitrequest !== 1'b0 && lat < 20);
        if (avs_if.avs_waitrequest !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL cpu_timeout: waitrequest=%b after %0d cycles, want 0", avs_if.avs_waitrequest, lat);
        end
        rdata = avs_if.avs_readdata;
        step();
        avs_if.avs_read  = 1'b0;
        avs_if.avs_write = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    initial begin
        logic [31:0] rdata;
        int          lat;
        vec_t        v;

        reset = 1'b1;
        jdo = 38'd0;
        clear_strobes();
        avs_if.avs_address = 8'h00; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
        avs_if.avs_writedata = 32'h0; avs_if.avs_byteenable = 4'h0; avs_if.debugaccess = 1'b0;

        // Reset values
        step(); step();
        check("rst_mondreg", mon_dreg, 32'h0);
        check("rst_readdata", avs_if.avs_readdata, 32'h0);
        check("rst_waitreq", {31'd0, avs_if.avs_waitrequest}, 32'd1);
        check("rst_busy", {31'd0, jtag_busy}, 32'd0);
        reset = 1'b0;
        step();
        check("idle_waitreq", {31'd0, avs_if.avs_waitrequest}, 32'd1);

        // Directed vector table
        add(OP_JA, 8'h10, 1'b0, 32'h0,        4'h0,    1'b0, 1'b0, 32'h0);
        add(OP_JB, 8'h00, 1'b0, 32'hDEADBEEF, 4'h0,    1'b0, 1'b1, 32'hDEADBEEF);
        add(OP_JB, 8'h00, 1'b0, 32'h11111111, 4'h0,    1'b0, 1'b1, 32'h11111111);
        add(OP_JB, 8'h00, 1'b0, 32'h22222222, 4'h0,    1'b0, 1'b1, 32'h22222222);
        add(OP_JA, 8'h10, 1'b1, 32'h0,        4'h0,    1'b0, 1'b1, 32'hDEADBEEF);
        add(OP_JN, 8'h00, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'h11111111);
        add(OP_JA, 8'h00, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'h11111111);
        add(OP_JB, 8'h00, 1'b0, 32'h5A5A5A5A, 4'h0,    1'b0, 1'b1, 32'h5A5A5A5A);
        add(OP_JB, 8'h00, 1'b0, 32'hA5A5A5A5, 4'h0,    1'b0, 1'b1, 32'hA5A5A5A5);
        add(OP_JA, 8'hFF, 1'b0, 32'h0,        4'h0,    1'b0, 1'b0, 32'h0);
        add(OP_JB, 8'h00, 1'b0, 32'hCAFEF00D, 4'h0,    1'b0, 1'b1, 32'hCAFEF00D);
        add(OP_JN, 8'h00, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'h5A5A5A5A);
        add(OP_JN, 8'h00, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'hA5A5A5A5);
        add(OP_JA, 8'hFF, 1'b1, 32'h0,        4'h0,    1'b0, 1'b1, 32'hCAFEF00D);
        add(OP_JN, 8'h00, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'h5A5A5A5A);
        add(OP_CW, 8'h03, 1'b0, 32'hAAAAAAAA, 4'b1111, 1'b1, 1'b1, 32'h0);
        add(OP_CW, 8'h03, 1'b0, 32'h12345678, 4'b0011, 1'b1, 1'b1, 32'h0);
        add(OP_CR, 8'h03, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'hAAAA5678);
        add(OP_CW, 8'h03, 1'b0, 32'h00000000, 4'b1111, 1'b0, 1'b1, 32'h0);
        add(OP_CR, 8'h03, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'hAAAA5678);
        add(OP_CR, 8'h10, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'hDEADBEEF);
        add(OP_CW, 8'h04, 1'b0, 32'h0F0F0F0F, 4'b1111, 1'b1, 1'b1, 32'h0);
        add(OP_CW, 8'h04, 1'b0, 32'hFFFFFFFF, 4'b1100, 1'b1, 1'b1, 32'h0);
        add(OP_JA, 8'h04, 1'b1, 32'h0,        4'h0,    1'b0, 1'b1, 32'hFFFF0F0F);
        add(OP_CW, 8'h04, 1'b0, 32'h00000000, 4'b1010, 1'b1, 1'b1, 32'h0);
        add(OP_CR, 8'h04, 1'b0, 32'h0,        4'h0,    1'b0, 1'b1, 32'h00FF000F);

        foreach (tbl[i]) begin
            v = tbl[i];
            if (v.op == OP_CW || v.op == OP_CR) begin
                cpu_op(v.op == OP_CW, v.addr, v.data, v.be, v.dbg, rdata, lat);
                check($sformatf("tbl%0d_latency", i), 32'(lat), (v.op == OP_CW) ? 32'd1 : 32'd2);
                if (v.op == OP_CR) check($sformatf("tbl%0d_readdata", i), rdata, v.exp);
            end else begin
                jtag_op(v.op, v.addr, v.rd, v.data);
                if (v.chk) check($sformatf("tbl%0d_mondreg", i), mon_dreg, v.exp);
            end
        end

        // JTAG read latency: new MonDReg exactly 3 cycles after the strobe
        set_strobe(OP_JA, 8'h10, 1'b1, 32'h0);
        step();
        clear_strobes();
        check("jrd_n1_busy", {31'd0, jtag_busy}, 32'd1);
        check("jrd_n1_hold", mon_dreg, 32'hFFFF0F0F);
        step();
        check("jrd_n2_hold", mon_dreg, 32'hFFFF0F0F);
        step();
        check("jrd_n3_data", mon_dreg, 32'hDEADBEEF);
        check("jrd_n3_busy", {31'd0, jtag_busy}, 32'd0);

        // JTAG write timing: MonDReg updated at N+1, done by N+2
        jtag_op(OP_JA, 8'h20, 1'b0, 32'h0);
        set_strobe(OP_JB, 8'h00, 1'b0, 32'h13572468);
        step();
        clear_strobes();
        check("jwr_n1_mondreg", mon_dreg, 32'h13572468);
        check("jwr_n1_busy", {31'd0, jtag_busy}, 32'd1);
        step();
        check("jwr_n2_busy", {31'd0, jtag_busy}, 32'd0);

        // Collision: CPU read and JTAG read strobe in the same cycle
        avs_if.avs_address = 8'h10;
        avs_if.avs_read = 1'b1;
        set_strobe(OP_JA, 8'h11, 1'b1, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) clear_strobes();
            if (k == 3) check("coll_jtag_data", mon_dreg, 32'h11111111);
            if (k < 5) check($sformatf("coll_wait_t%0d", k), {31'd0, avs_if.avs_waitrequest}, 32'd1);
        end
        check("coll_cpu_done", {31'd0, avs_if.avs_waitrequest}, 32'd0);
        check("coll_cpu_data", avs_if.avs_readdata, 32'hDEADBEEF);
        step();
        avs_if.avs_read = 1'b0;

        // JTAG strobe arriving during CRD is serviced after CRD_DONE
        avs_if.avs_address = 8'h20;
        avs_if.avs_read = 1'b1;
        step();
        check("crd_wait_t1", {31'd0, avs_if.avs_waitrequest}, 32'd1);
        set_strobe(OP_JN, 8'h00, 1'b0, 32'h0);
        step();
        clear_strobes();
        check("crd_done_wait", {31'd0, avs_if.avs_waitrequest}, 32'd0);
        check("crd_done_data", avs_if.avs_readdata, 32'h13572468);
        check("crd_done_busy", {31'd0, jtag_busy}, 32'd1);
        step();
        avs_if.avs_read = 1'b0;
        check("crd_t3_hold", mon_dreg, 32'h11111111);
        step(); step();
        check("crd_t5_hold", mon_dreg, 32'h11111111);
        step();
        check("crd_t6_data", mon_dreg, 32'h22222222);
        check("crd_t6_busy", {31'd0, jtag_busy}, 32'd0);

        // Reset asserted in the JWR cycle aborts the write
        jtag_op(OP_JA, 8'h10, 1'b0, 32'h0);
        set_strobe(OP_JB, 8'h00, 1'b0, 32'h99999999);
        step();
        clear_strobes();
        reset = 1'b1;
        check("jwr_rst_pre", mon_dreg, 32'h99999999);
        step();
        reset = 1'b0;
        check("jwr_rst_mondreg", mon_dreg, 32'h0);
        check("jwr_rst_busy", {31'd0, jtag_busy}, 32'd0);
        check("jwr_rst_waitreq", {31'd0, avs_if.avs_waitrequest}, 32'd1);
        check("jwr_rst_readdata", avs_if.avs_readdata, 32'h0);
        jtag_op(OP_JN, 8'h00, 1'b0, 32'h0);
        check("jwr_rst_areg0", mon_dreg, 32'h5A5A5A5A);
        jtag_op(OP_JA, 8'h10, 1'b1, 32'h0);
        check("jwr_rst_ram_kept", mon_dreg, 32'hDEADBEEF);

        // Random phase: fill the whole RAM through JTAG, then mixed traffic
        md = 32'hDEADBEEF;
        jtag_op(OP_JA, 8'h00, 1'b0, 32'h0);
        ma = 8'h00;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = $urandom();
            jtag_op(OP_JB, 8'h00, 1'b0, d);
            mm[ma] = d;
            ma = ma + 8'd1;
            md = d;
        end
        check("fill_mondreg", mon_dreg, md);

        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  be;
            logic        rd, dbg;
            sel = $urandom_range(0, 4);
            a   = 8'($urandom());
            d   = $urandom();
            be  = 4'($urandom());
            rd  = 1'($urandom());
            dbg = ($urandom_range(0, 3) != 0);
            case (sel)
                0: begin
                    jtag_op(OP_JA, a, rd, d);
                    ma = a;
                    if (rd) begin md = mm[ma]; ma = ma + 8'd1; end
                    check($sformatf("rnd%0d_ja", i), mon_dreg, md);
                end
                1: begin
                    jtag_op(OP_JN, a, rd, d);
                    md = mm[ma];
                    ma = ma + 8'd1;
                    check($sformatf("rnd%0d_jn", i), mon_dreg, md);
                end
                2: begin
                    jtag_op(OP_JB, a, rd, d);
                    mm[ma] = d;
                    md = d;
                    ma = ma + 8'd1;
                    check($sformatf("rnd%0d_jb", i), mon_dreg, md);
                end
                3: begin
                    cpu_op(1'b1, a, d, be, dbg, rdata, lat);
                    if (dbg) mm[a] = merge(mm[a], d, be);
                    check($sformatf("rnd%0d_cw_lat", i), 32'(lat), 32'd1);
                end
                default: begin
                    cpu_op(1'b0, a, d, be, dbg, rdata, lat);
                    check($sformatf("rnd%0d_cr_lat", i), 32'(lat), 32'd2);
                    check($sformatf("rnd%0d_cr_data", i), rdata, mm[a]);
                end
            endcase
            repeat ($urandom_range(0, 2)) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
